// File: rtl/ce_strobe_gen_pkg.sv
// Shared types and default widths for the CE strobe generator and its counters.
package ce_strobe_gen_pkg;

    localparam int CNT_W_DEFAULT   = 16;
    localparam int BURST_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // A zero period is treated as a period of one clock.
    function automatic logic [CNT_W_DEFAULT-1:0] eff_div(input logic [CNT_W_DEFAULT-1:0] d);
        return (d == '0) ? CNT_W_DEFAULT'(1) : d;
    endfunction

endpackage

// File: rtl/ce_down_counter.sv
// Loadable down counter that stops at zero and flags when it holds zero.
module ce_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ce_strobe_gen.sv
// Programmable clock-enable strobe generator: single-cycle CE pulses every DIV clocks,
// for a finite burst or continuously, with hold and stop.
module ce_strobe_gen
    import ce_strobe_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int BURST_W = BURST_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic [CNT_W-1:0]   div,
    input  logic [BURST_W-1:0] burst,
    output logic               ce,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   div_eff_q, div_eff_d;
    logic               cont_q, cont_d;
    logic               ce_q, ce_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               per_load, per_en, per_zero;
    logic [CNT_W-1:0]   per_val;
    logic               rem_load, rem_en, rem_zero;
    logic [BURST_W-1:0] rem_val;
    logic [CNT_W-1:0]   div_in_eff;

    assign div_in_eff = (div == '0) ? CNT_W'(1) : div;

    ce_down_counter #(.W(CNT_W)) u_period (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (per_load),
        .load_val (per_val),
        .en       (per_en),
        .zero     (per_zero)
    );

    ce_down_counter #(.W(BURST_W)) u_remain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rem_load),
        .load_val (rem_val),
        .en       (rem_en),
        .zero     (rem_zero)
    );

    always_comb begin
        state_d   = state_q;
        div_eff_d = div_eff_q;
        cont_d    = cont_q;
        ce_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        per_load  = 1'b0;
        per_val   = '0;
        per_en    = 1'b0;
        rem_load  = 1'b0;
        rem_val   = '0;
        rem_en    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && !stop) begin
                    div_eff_d = div_in_eff;
                    cont_d    = (burst == '0);
                    ce_d      = 1'b1;
                    busy_d    = 1'b1;
                    per_load  = 1'b1;
                    per_val   = div_in_eff - CNT_W'(1);
                    // The accept edge issues pulse one, so the remaining counter holds
                    // pulses still owed beyond the next one; zero then marks the last.
                    rem_load  = 1'b1;
                    rem_val   = (burst > BURST_W'(1)) ? burst - BURST_W'(2) : '0;
                    state_d   = (burst == BURST_W'(1)) ? FIN : RUN;
                end
            end

            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    per_load = 1'b1;
                    rem_load = 1'b1;
                end else if (!hold) begin
                    if (per_zero) begin
                        ce_d     = 1'b1;
                        per_load = 1'b1;
                        per_val  = div_eff_q - CNT_W'(1);
                        if (!cont_q) begin
                            if (rem_zero) begin
                                state_d = FIN;
                            end else begin
                                rem_en = 1'b1;
                            end
                        end
                    end else begin
                        per_en = 1'b1;
                    end
                end
            end

            FIN: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                per_load = 1'b1;
                rem_load = 1'b1;
                done_d   = !stop;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_eff_q <= '0;
            cont_q    <= 1'b0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_eff_q <= div_eff_d;
            cont_q    <= cont_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ce   = ce_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ce_strobe_gen.sv
// Self-checking bench for ce_strobe_gen; expected {ce,busy,done} per cycle go through a scoreboard queue.
module tb_ce_strobe_gen;

    typedef struct {
        logic [2:0] val;
        int         cyc;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        hold;
    logic [15:0] div;
    logic [7:0]  burst;
    logic        ce;
    logic        busy;
    logic        done;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    ce_strobe_gen #(.CNT_W(16), .BURST_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .hold  (hold),
        .div   (div),
        .burst (burst),
        .ce    (ce),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Cycle c is the clock period following edge c-1; inputs for that edge are set first.
    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; hold = 1'b0; div = 16'd4; burst = 8'd3;
        #3;
        sb_q.push_back('{val: 3'b000, cyc: 0, tag: "reset_async"});
        e = sb_q.pop_front(); vec_cnt++;
        if ({ce, busy, done} !== e.val) begin
            err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
        end
        for (int c = 1; c <= 3; c++) begin
            sb_q.push_back('{val: 3'b000, cyc: c, tag: "reset_held"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0;
        #2 rst_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            sb_q.push_back('{val: 3'b000, cyc: c, tag: "reset_idle"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
    endtask

    task automatic test_burst_basic();
        exp_t e;
        div = 16'd4; burst = 8'd3;
        for (int c = 1; c <= 13; c++) begin
            start = (c == 1);
            sb_q.push_back('{val: {(c == 1 || c == 5 || c == 9), (c <= 9), (c == 10)}, cyc: c, tag: "burst_div4"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_div_zero_and_single();
        exp_t e;
        div = 16'd0; burst = 8'd2;
        for (int c = 1; c <= 5; c++) begin
            start = (c == 1);
            sb_q.push_back('{val: {(c <= 2), (c <= 2), (c == 3)}, cyc: c, tag: "div0"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        div = 16'd2; burst = 8'd1;
        for (int c = 1; c <= 4; c++) begin
            start = (c == 1);
            sb_q.push_back('{val: {(c == 1), (c == 1), (c == 2)}, cyc: c, tag: "burst1"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_continuous_stop();
        exp_t e;
        div = 16'd3; burst = 8'd0;
        for (int c = 1; c <= 14; c++) begin
            start = (c == 1);
            stop  = (c == 11);
            sb_q.push_back('{val: {(c == 1 || c == 4 || c == 7 || c == 10), (c <= 10), 1'b0}, cyc: c, tag: "cont_stop"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_hold();
        exp_t e;
        div = 16'd5; burst = 8'd2;
        for (int c = 1; c <= 12; c++) begin
            start = (c == 1);
            hold  = (c >= 4 && c <= 6);
            sb_q.push_back('{val: {(c == 1 || c == 9), (c <= 9), (c == 10)}, cyc: c, tag: "hold"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0; hold = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 1; c <= 16; c++) begin
            div   = (c >= 3) ? 16'd2 : 16'd4;
            burst = (c >= 3) ? 8'd2 : 8'd3;
            start = (c == 1 || c == 3 || c == 6 || c == 11);
            sb_q.push_back('{val: {(c == 1 || c == 5 || c == 9 || c == 11 || c == 13),
                                   (c <= 9 || (c >= 11 && c <= 13)),
                                   (c == 10 || c == 14)}, cyc: c, tag: "retrig_b2b"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        div = 16'd4; burst = 8'd3;
        for (int c = 1; c <= 5; c++) begin
            start = (c == 1);
            sb_q.push_back('{val: {(c == 1 || c == 5), 1'b1, 1'b0}, cyc: c, tag: "pre_reset"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        sb_q.push_back('{val: 3'b000, cyc: 5, tag: "mid_reset"});
        #1;
        e = sb_q.pop_front(); vec_cnt++;
        if ({ce, busy, done} !== e.val) begin
            err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            sb_q.push_back('{val: 3'b000, cyc: c, tag: "post_reset"});
            @(posedge clk); #1;
            e = sb_q.pop_front(); vec_cnt++;
            if ({ce, busy, done} !== e.val) begin
                err_cnt++; $display("FAIL %s cycle %0d: {ce,busy,done}=%b want %b", e.tag, e.cyc, {ce, busy, done}, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst_basic();
        test_div_zero_and_single();
        test_continuous_stop();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vec_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
